barcodescanner_nios_ddr2_memory_ex_prbs: RTL and testbench



---
 rtl/barcodescanner_nios_ddr2_memory_ex_pkg.sv | 22 ++
 rtl/barcodescanner_nios_ddr2_memory_ex_prbs_chk.sv | 96 +++++++++
 rtl/barcodescanner_nios_ddr2_memory_ex_prbs.sv | 40 ++++
 tb/tb_barcodescanner_nios_ddr2_memory_ex_prbs.sv | 123 ++++++++++++
 4 files changed

// File: rtl/barcodescanner_nios_ddr2_memory_ex_pkg.sv
// barcodescanner_nios_ddr2_memory_ex_pkg: shared checker states, default polynomials and LFSR step
package barcodescanner_nios_ddr2_memory_ex_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEEK = 2'd1;
  localparam logic [1:0] ST_VERIFY = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SEEK = ST_SEEK,
    VERIFY = ST_VERIFY,
    LOCKED = ST_LOCKED
  } chk_state_e;
  localparam logic [7:0] TAPS_8 = 8'h1D;
  localparam logic [15:0] TAPS_16 = 16'h002D;
  localparam logic [31:0] TAPS_32 = 32'h000000C5;
  // Galois step on the low w bits of a 32-bit container; upper bits are zeroed
  function automatic logic [31:0] step(input logic [31:0] x, input logic [31:0] taps, input int w);
    logic [31:0] m;
    m = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return ((x << 1) ^ ({32{x[w-1]}} & taps)) & m;
  endfunction
endpackage

// File: rtl/barcodescanner_nios_ddr2_memory_ex_prbs_chk.sv
// barcodescanner_nios_ddr2_memory_ex_prbs_chk: self-synchronising LFSR pattern checker
module barcodescanner_nios_ddr2_memory_ex_prbs_chk
  import barcodescanner_nios_ddr2_memory_ex_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(TAPS_8),
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chk_start,
  input  logic             chk_valid,
  input  logic [WIDTH-1:0] chk_data,
  output logic             chk_locked,
  output logic             chk_err,
  output logic [CNT_W-1:0] err_count
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
    return WIDTH'(step(32'(x), 32'(TAPS), WIDTH));
  endfunction
  chk_state_e state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [MW-1:0] match_q, match_d;
  logic [LW-1:0] miss_q, miss_d;
  logic err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      exp_q <= '0;
      match_q <= '0;
      miss_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      exp_q <= exp_d;
      match_q <= match_d;
      miss_q <= miss_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    exp_d = exp_q;
    match_d = match_q;
    miss_d = miss_q;
    err_d = 1'b0;
    cnt_d = cnt_q;
    if (chk_start) begin
      state_d = SEEK;
      match_d = '0;
      miss_d = '0;
      cnt_d = '0;
    end else if (chk_valid) begin
      case (state_q)
        SEEK: if (chk_data != '0) begin
          exp_d = nxt(chk_data);
          match_d = '0;
          state_d = VERIFY;
        end
        VERIFY: if (chk_data == exp_q) begin
          exp_d = nxt(exp_q);
          match_d = match_q + MW'(1);
          if (match_q == MW'(LOCK_CNT - 1)) begin
            state_d = LOCKED;
            miss_d = '0;
          end
        end else begin
          exp_d = nxt(chk_data);
          match_d = '0;
          state_d = (chk_data == '0) ? SEEK : VERIFY;
        end
        LOCKED: begin
          exp_d = nxt(exp_q);
          if (chk_data == exp_q) miss_d = '0;
          else begin
            err_d = 1'b1;
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            miss_d = miss_q + LW'(1);
            state_d = (miss_q == LW'(LOSS_CNT - 1)) ? SEEK : LOCKED;
          end
        end
        default: ;
      endcase
    end
  end
  assign chk_locked = (state_q == LOCKED);
  assign chk_err = err_q;
  assign err_count = cnt_q;
endmodule

// File: rtl/barcodescanner_nios_ddr2_memory_ex_prbs.sv
// barcodescanner_nios_ddr2_memory_ex_prbs: Galois-LFSR pattern generator with independent pattern checker
module barcodescanner_nios_ddr2_memory_ex_prbs
  import barcodescanner_nios_ddr2_memory_ex_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(TAPS_8),
  parameter int SEED = 32,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pause,
  input  logic             load,
  input  logic [WIDTH-1:0] ldata,
  output logic [WIDTH-1:0] data,
  input  logic             chk_start,
  input  logic             chk_valid,
  input  logic [WIDTH-1:0] chk_data,
  output logic             chk_locked,
  output logic             chk_err,
  output logic [CNT_W-1:0] err_count
);
  localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);
  logic [WIDTH-1:0] data_q, data_d;
  always_comb data_d = (reset || !enable) ? SEED_W :
                       load ? ldata :
                       pause ? data_q :
                       WIDTH'(step(32'(data_q), 32'(TAPS), WIDTH));
  always_ff @(posedge clk) data_q <= data_d;
  assign data = data_q;
  barcodescanner_nios_ddr2_memory_ex_prbs_chk #(
    .WIDTH(WIDTH), .TAPS(TAPS), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(CNT_W)
  ) u_chk (
    .clk(clk), .reset(reset), .chk_start(chk_start), .chk_valid(chk_valid), .chk_data(chk_data),
    .chk_locked(chk_locked), .chk_err(chk_err), .err_count(err_count)
  );
endmodule

// File: tb/tb_barcodescanner_nios_ddr2_memory_ex_prbs.sv
// tb_barcodescanner_nios_ddr2_memory_ex_prbs: directed checks of generator and checker
module tb_barcodescanner_nios_ddr2_memory_ex_prbs;
  logic clk = 0, reset = 0, enable = 0, pause = 0, load = 0;
  logic [7:0] ldata = 0, data, data2, chk_data = 0;
  logic chk_start = 0, chk_valid = 0, chk_locked, chk_err, locked2, err2;
  logic [15:0] err_count;
  logic [1:0] cnt2;
  int n = 0, f = 0;
  always #5 clk = ~clk;
  barcodescanner_nios_ddr2_memory_ex_prbs dut (
    .clk(clk), .reset(reset), .enable(enable), .pause(pause), .load(load), .ldata(ldata), .data(data),
    .chk_start(chk_start), .chk_valid(chk_valid), .chk_data(chk_data),
    .chk_locked(chk_locked), .chk_err(chk_err), .err_count(err_count));
  barcodescanner_nios_ddr2_memory_ex_prbs #(.CNT_W(2), .LOSS_CNT(8)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .pause(pause), .load(load), .ldata(ldata), .data(data2),
    .chk_start(chk_start), .chk_valid(chk_valid), .chk_data(chk_data),
    .chk_locked(locked2), .chk_err(err2), .err_count(cnt2));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] w);
    chk_valid = 1; chk_data = w; tick(); chk_valid = 0;
  endtask
  task automatic start();
    chk_start = 1; tick(); chk_start = 0;
  endtask
  task automatic lock_seq();
    start(); send(8'h20); send(8'h40); send(8'h80); send(8'h1D); send(8'h3A);
  endtask
  task automatic test_reset();
    reset = 1; enable = 1; tick(); reset = 0;
    n++; if (data !== 8'h20) begin f++; $display("FAIL reset_data: got %h want 20", data); end
    n++; if (chk_locked !== 1'b0 || chk_err !== 1'b0) begin f++; $display("FAIL reset_flags: locked=%b err=%b want 0 0", chk_locked, chk_err); end
    n++; if (err_count !== 16'd0) begin f++; $display("FAIL reset_count: got %0d want 0", err_count); end
  endtask
  task automatic test_gen_seq();
    logic [7:0] e [8] = '{8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD};
    for (int i = 0; i < 8; i++) begin
      n++; if (data !== e[i]) begin f++; $display("FAIL gen_seq[%0d]: got %h want %h", i, data, e[i]); end
      tick();
    end
  endtask
  task automatic test_pause_load();
    enable = 0; tick(); enable = 1;
    n++; if (data !== 8'h20) begin f++; $display("FAIL disable_seed: got %h want 20", data); end
    tick(); tick(); pause = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n++; if (data !== 8'h80) begin f++; $display("FAIL pause_hold[%0d]: got %h want 80", i, data); end
    end
    pause = 0; tick();
    n++; if (data !== 8'h1D) begin f++; $display("FAIL pause_resume: got %h want 1d", data); end
    load = 1; ldata = 8'hCD; pause = 1; tick(); load = 0; pause = 0;
    n++; if (data !== 8'hCD) begin f++; $display("FAIL load_over_pause: got %h want cd", data); end
    tick();
    n++; if (data !== 8'h87) begin f++; $display("FAIL step_after_load: got %h want 87", data); end
    load = 1; ldata = 8'h00; tick(); load = 0; tick(); tick();
    n++; if (data !== 8'h00) begin f++; $display("FAIL zero_hold: got %h want 00", data); end
    enable = 0; tick(); enable = 1;
    n++; if (data !== 8'h20) begin f++; $display("FAIL enable_low: got %h want 20", data); end
  endtask
  task automatic test_lock();
    start();
    send(8'h20); tick(); send(8'h40); send(8'h80); tick(); tick(); send(8'h1D);
    n++; if (chk_locked !== 1'b0) begin f++; $display("FAIL early_lock: got %b want 0", chk_locked); end
    send(8'h3A);
    n++; if (chk_locked !== 1'b1) begin f++; $display("FAIL lock: got %b want 1", chk_locked); end
    n++; if (err_count !== 16'd0) begin f++; $display("FAIL lock_count: got %0d want 0", err_count); end
  endtask
  task automatic test_errors();
    send(8'h00);
    n++; if (chk_err !== 1'b1 || err_count !== 16'd1) begin f++; $display("FAIL err_pulse: err=%b cnt=%0d want 1 1", chk_err, err_count); end
    send(8'hE8);
    n++; if (chk_err !== 1'b0 || chk_locked !== 1'b1) begin f++; $display("FAIL err_single: err=%b locked=%b want 0 1", chk_err, chk_locked); end
    send(8'h00); send(8'h00);
    n++; if (chk_locked !== 1'b1) begin f++; $display("FAIL early_loss: got %b want 1", chk_locked); end
    send(8'h00);
    n++; if (chk_locked !== 1'b0 || err_count !== 16'd4) begin f++; $display("FAIL loss: locked=%b cnt=%0d want 0 4", chk_locked, err_count); end
    tick();
    n++; if (chk_err !== 1'b0 || err_count !== 16'd4) begin f++; $display("FAIL after_loss: err=%b cnt=%0d want 0 4", chk_err, err_count); end
  endtask
  task automatic test_seek_zero();
    start();
    n++; if (err_count !== 16'd0) begin f++; $display("FAIL start_clear: got %0d want 0", err_count); end
    for (int i = 0; i < 6; i++) send(8'h00);
    n++; if (chk_locked !== 1'b0) begin f++; $display("FAIL zero_guard: got %b want 0", chk_locked); end
    send(8'h20); send(8'h40); send(8'h80); send(8'h1D); send(8'h3A);
    n++; if (chk_locked !== 1'b1) begin f++; $display("FAIL seek_relock: got %b want 1", chk_locked); end
  endtask
  task automatic test_start_priority();
    chk_start = 1; chk_valid = 1; chk_data = 8'h00; tick(); chk_start = 0; chk_valid = 0;
    n++; if (chk_locked !== 1'b0 || chk_err !== 1'b0) begin f++; $display("FAIL start_prio: locked=%b err=%b want 0 0", chk_locked, chk_err); end
  endtask
  task automatic test_saturate();
    lock_seq();
    n++; if (locked2 !== 1'b1) begin f++; $display("FAIL sat_lock: got %b want 1", locked2); end
    for (int i = 0; i < 5; i++) send(8'h00);
    n++; if (cnt2 !== 2'd3 || locked2 !== 1'b1) begin f++; $display("FAIL saturate: cnt=%0d locked=%b want 3 1", cnt2, locked2); end
  endtask
  task automatic test_reset_mid();
    lock_seq();
    send(8'h00);
    reset = 1; chk_valid = 1; chk_data = 8'h00; load = 1; ldata = 8'h55; tick(); reset = 0; chk_valid = 0; load = 0;
    n++; if (chk_locked !== 1'b0 || chk_err !== 1'b0 || err_count !== 16'd0) begin f++; $display("FAIL reset_mid: locked=%b err=%b cnt=%0d want 0 0 0", chk_locked, chk_err, err_count); end
    n++; if (data !== 8'h20) begin f++; $display("FAIL reset_mid_data: got %h want 20", data); end
    send(8'h20);
    n++; if (chk_locked !== 1'b0) begin f++; $display("FAIL reset_idle: got %b want 0", chk_locked); end
  endtask
  initial begin
    test_reset();
    test_gen_seq();
    test_pause_load();
    test_lock();
    test_errors();
    test_seek_zero();
    test_start_priority();
    test_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n, f);
    $finish;
  end
endmodule
